// File: rtl/unit_align_mant_pipe.sv
// ============================================================================
// unit_align_mant_pipe
// ----------------------------------------------------------------------------
// Two-stage mantissa alignment and operand-select stage of the FP adder.
//   S1: extends both mantissas with the hidden bit and GRS_W guard bits,
//       picks the operand with the smaller exponent and right-shifts it by
//       E_sub (clamped to the extended width W).
//   S2: orders the aligned pair so that Augend >= Addend and reports on
//       C_mant whether the unshifted operand was strictly larger.
// Valid/ready handshake on both sides; at most two beats in flight.
//
// Optional build macro:
//   ALIGN_STICKY_EN - when defined, the OR of all bits shifted out of the
//                     smaller operand is folded into bit 0 of the shifted
//                     value before the S2 compare. Undefined: plain
//                     truncating shift.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        input beat valid
//   in_ready   out  1        stage accepts a beat this cycle
//   Mant_A     in   MANT_W   stored mantissa A (no hidden bit)
//   Mant_B     in   MANT_W   stored mantissa B (no hidden bit)
//   E_sub      in   EXP_W    |Ea-Eb|, unsigned shift amount
//   Ce         in   1        1: shift A (Eb larger), 0: shift B
//   out_valid  out  1        output beat valid
//   out_ready  in   1        downstream accepts the beat
//   Augend     out  W        larger aligned mantissa
//   Addend     out  W        smaller aligned mantissa
//   C_mant     out  1        1 when unshifted operand > shifted operand
// ============================================================================
module unit_align_mant_pipe #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8,
    parameter int GRS_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MANT_W-1:0]         Mant_A,
    input  logic [MANT_W-1:0]         Mant_B,
    input  logic [EXP_W-1:0]          E_sub,
    input  logic                      Ce,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MANT_W+GRS_W:0]     Augend,
    output logic [MANT_W+GRS_W:0]     Addend,
    output logic                      C_mant
);

    localparam int W    = MANT_W + 1 + GRS_W;
    localparam int SH_W = $clog2(W + 1);
    // Common width for comparing E_sub against W without truncating either.
    localparam int CW   = (EXP_W > SH_W) ? EXP_W : SH_W;

    // Any shift of W or more empties the operand, so clamp to W.
    function automatic logic [SH_W-1:0] clamp_shift(input logic [EXP_W-1:0] e);
        if (CW'(e) >= CW'(W)) begin
            return SH_W'(W);
        end
        return SH_W'(e);
    endfunction

    // Logical right shift with optional sticky collection of lost bits.
    function automatic logic [W-1:0] align_shift(input logic [W-1:0] m,
                                                 input logic [SH_W-1:0] sh);
        logic [W-1:0] r;
        r = m >> sh;
`ifdef ALIGN_STICKY_EN
        // Mask of the low sh bits; a shift by W yields an all-ones mask.
        r[0] = r[0] | (|(m & ~({W{1'b1}} << sh)));
`endif
        return r;
    endfunction

    logic [W-1:0] m_a, m_b, m_em, m_el;
    logic         vld_p1, vld_p2;
    logic [W-1:0] em_p1, sr_p1;
    logic [W-1:0] aug_p2, add_p2;
    logic         cm_p2;
    logic         s2_adv, in_fire, sel;

    assign m_a  = {1'b1, Mant_A, {GRS_W{1'b0}}};
    assign m_b  = {1'b1, Mant_B, {GRS_W{1'b0}}};
    assign m_em = Ce ? m_b : m_a;
    assign m_el = Ce ? m_a : m_b;

    assign s2_adv   = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready = !vld_p1 || s2_adv;
    assign in_fire  = in_valid && in_ready;

    // ---- stage 1: extend, select and align --------------------------------
    always_ff @(posedge clk) begin
        if (in_fire) begin
            em_p1 <= m_em;
            sr_p1 <= align_shift(m_el, clamp_shift(E_sub));
        end
    end

    // Equal values give sel=0, so the shifted operand lands on Augend.
    assign sel = (em_p1 > sr_p1);

    // ---- stage 2: order the pair; control and visible outputs -------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            aug_p2 <= '0;
            add_p2 <= '0;
            cm_p2  <= 1'b0;
        end else begin
            if (in_ready) begin
                vld_p1 <= in_valid;
            end
            if (s2_adv) begin
                vld_p2 <= 1'b1;
                aug_p2 <= sel ? em_p1 : sr_p1;
                add_p2 <= sel ? sr_p1 : em_p1;
                cm_p2  <= sel;
            end else if (out_ready) begin
                vld_p2 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p2;
    assign Augend    = aug_p2;
    assign Addend    = add_p2;
    assign C_mant    = cm_p2;

endmodule

// File: tb/tb_unit_align_mant_pipe.sv
// ============================================================================
// tb_unit_align_mant_pipe
// Directed vector table, stall and reset sequences, then randomized traffic
// checked by a scoreboard fed from an arithmetic reference model.
// ============================================================================
module tb_unit_align_mant_pipe;

    localparam int MANT_W = 23;
    localparam int EXP_W  = 8;
    localparam int GRS_W  = 4;
    localparam int W      = MANT_W + 1 + GRS_W;

`ifdef ALIGN_STICKY_EN
    localparam logic [W-1:0] STK = 1;
    localparam bit STICKY_ON = 1'b1;
`else
    localparam logic [W-1:0] STK = 0;
    localparam bit STICKY_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] Mant_A, Mant_B;
    logic [EXP_W-1:0]  E_sub;
    logic              Ce;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      Augend, Addend;
    logic              C_mant;

    unit_align_mant_pipe #(.MANT_W(MANT_W), .EXP_W(EXP_W), .GRS_W(GRS_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Mant_A(Mant_A), .Mant_B(Mant_B), .E_sub(E_sub), .Ce(Ce),
        .out_valid(out_valid), .out_ready(out_ready),
        .Augend(Augend), .Addend(Addend), .C_mant(C_mant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] aug;
        logic [W-1:0] add;
        logic         c;
    } res_t;

    typedef struct {
        logic [MANT_W-1:0] a;
        logic [MANT_W-1:0] b;
        logic              ce;
        logic [EXP_W-1:0]  e;
        logic [W-1:0]      aug;
        logic [W-1:0]      add;
        logic              c;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: operands as integers, shift as division, lost bits as remainder.
    function automatic res_t ref_model(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                                       input logic ce, input logic [EXP_W-1:0] e);
        longint ma, mb, em, el, sr, div;
        bit     lost;
        res_t   r;
        ma = (longint'(1) << (MANT_W + GRS_W)) + longint'(a) * (longint'(1) << GRS_W);
        mb = (longint'(1) << (MANT_W + GRS_W)) + longint'(b) * (longint'(1) << GRS_W);
        em = ce ? mb : ma;
        el = ce ? ma : mb;
        if (int'(e) >= W) begin
            sr   = 0;
            lost = (el != 0);
        end else begin
            div  = longint'(1) << int'(e);
            sr   = el / div;
            lost = (el % div) != 0;
        end
        if (STICKY_ON && lost) sr = sr | 1;
        if (em > sr) begin
            r.aug = W'(em); r.add = W'(sr); r.c = 1'b1;
        end else begin
            r.aug = W'(sr); r.add = W'(em); r.c = 1'b0;
        end
        return r;
    endfunction

    // Scoreboard state
    res_t         exp_q[$];
    bit           sb_on = 1'b0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_aug, prev_add;
    logic         prev_c;

    task automatic sb_step();
        res_t r;
        if (!sb_on) begin
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_augend", Augend, prev_aug);
            check("hold_addend", Addend, prev_add);
            check("hold_cmant", C_mant, prev_c);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_beat: got Augend=0x%0h with no beat outstanding", Augend);
            end else begin
                r = exp_q.pop_front();
                check("sb_augend", Augend, r.aug);
                check("sb_addend", Addend, r.add);
                check("sb_cmant", C_mant, r.c);
            end
        end
        if (in_valid && in_ready) exp_q.push_back(ref_model(Mant_A, Mant_B, Ce, E_sub));
        prev_stall = out_valid && !out_ready;
        prev_aug = Augend;
        prev_add = Addend;
        prev_c   = C_mant;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            sb_step();
        end
    end

    task automatic drive(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b,
                         input logic ce, input logic [EXP_W-1:0] e);
        in_valid = 1'b1;
        Mant_A = a; Mant_B = b; Ce = ce; E_sub = e;
    endtask

    vec_t tbl[10];

    initial begin
        int cyc;
        bit f;
        int sent;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Mant_A = '0; Mant_B = '0; E_sub = '0; Ce = 1'b0;

        //          a          b          ce  e     aug             add                   c
        tbl[0] = '{23'h000000, 23'h000000, 0, 1,   28'h8000000, 28'h4000000,        1};
        tbl[1] = '{23'h7FFFFF, 23'h000000, 1, 0,   28'hFFFFFF0, 28'h8000000,        0};
        tbl[2] = '{23'h123456, 23'h123456, 0, 0,   28'h9234560, 28'h9234560,        0};
        tbl[3] = '{23'h000000, 23'h000000, 0, 200, 28'h8000000, 28'h0000000 | STK,  1};
        tbl[4] = '{23'h000000, 23'h000001, 0, 5,   28'h8000000, 28'h0400000 | STK,  1};
        tbl[5] = '{23'h000000, 23'h7FFFFF, 1, 28,  28'hFFFFFF0, 28'h0000000 | STK,  1};
        tbl[6] = '{23'h000000, 23'h7FFFFF, 0, 0,   28'hFFFFFF0, 28'h8000000,        0};
        tbl[7] = '{23'h000001, 23'h7FFFFF, 0, 27,  28'h8000010, 28'h0000001,        1};
        tbl[8] = '{23'h000000, 23'h000001, 0, 4,   28'h8000000, 28'h0800001,        1};
        tbl[9] = '{23'h000000, 23'h000000, 1, 255, 28'h8000000, 28'h0000000 | STK,  1};

        // Reset values
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_augend", Augend, 0);
        check("rst_addend", Addend, 0);
        check("rst_cmant", C_mant, 0);
        check("rst_in_ready", in_ready, 1);

        // Table vectors, one beat at a time, with latency check
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(tbl[i].a, tbl[i].b, tbl[i].ce, tbl[i].e);
            out_ready = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", i), in_ready, 1);
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_early_valid", i), out_valid, 0);
            @(negedge clk);
            check($sformatf("vec%0d_out_valid", i), out_valid, 1);
            check($sformatf("vec%0d_augend", i), Augend, tbl[i].aug);
            check($sformatf("vec%0d_addend", i), Addend, tbl[i].add);
            check($sformatf("vec%0d_cmant", i), C_mant, tbl[i].c);
        end
        @(posedge clk); #1;

        // Stall: three back-to-back beats with out_ready low
        sb_on = 1'b1;
        out_ready = 1'b0;
        drive(23'h0ABCDE, 23'h012345, 1'b0, 8'd3);
        @(negedge clk); check("stall_b0_ready", in_ready, 1);
        @(posedge clk); #1 drive(23'h7FFFFF, 23'h000010, 1'b1, 8'd7);
        @(negedge clk); check("stall_b1_ready", in_ready, 1);
        @(posedge clk); #1 drive(23'h222222, 23'h333333, 1'b0, 8'd0);
        @(negedge clk);
        check("stall_b2_blocked", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        repeat (3) begin
            @(negedge clk);
            check("stall_still_blocked", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk); check("stall_release_ready", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("stall_all_emerged", exp_q.size(), 0);

        // Reset with two beats in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(23'h111111, 23'h222222, 1'b0, 8'd2);
        @(posedge clk); #1 drive(23'h333333, 23'h444444, 1'b1, 8'd9);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_on = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_augend", Augend, 0);
        check("flush_addend", Addend, 0);
        check("flush_cmant", C_mant, 0);
        check("flush_in_ready", in_ready, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("flush_no_stale", out_valid, 0);
        end

        // Random traffic against the reference model
        sb_on = 1'b1;
        sent = 0;
        cyc = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            @(negedge clk);
            f = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (f) sent++;
            if (!in_valid || f) begin
                if (sent < 1000 && $urandom_range(0, 9) < 7) begin
                    Mant_A = MANT_W'($urandom);
                    Mant_B = ($urandom_range(0, 7) == 0) ? Mant_A : MANT_W'($urandom);
                    Ce     = 1'($urandom);
                    E_sub  = ($urandom_range(0, 3) == 0) ? EXP_W'($urandom_range(0, 255))
                                                         : EXP_W'($urandom_range(0, 30));
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
        end
        check("random_all_sent", sent, 1000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        check("random_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
